decoder8_pulse: RTL and testbench

- Registered 3-to-8 one-hot decoder with a valid/ready input handshake and timed output pulses; the inverse of the team's 8-to-3 priority encoder.
- Each accepted 3-bit code drives one bit of an 8-bit strobe bus for PULSE_LEN cycles, followed by GAP_LEN idle cycles.
- A one-entry holding buffer lets the next code be accepted while the current pulse is still being driven.
- Sits between control logic that produces encoded select values and downstream blocks that need one-hot enable strobes.

---
 rtl/decoder8_pulse.sv | 144 ++++++++++++++
 tb/tb_decoder8_pulse.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder8_pulse.sv
// Registered 3-to-8 one-hot decoder with a one-entry input buffer and timed
// output pulses: PULSE_LEN cycles of strobe, then GAP_LEN forced-idle cycles.
module decoder8_pulse #(
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 1,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_code,
   input  logic       in_en,
   output logic [7:0] y,
   output logic       y_valid,
   output logic       y_last,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_RELOAD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             hold_full_reg, hold_full_next;
   logic [2:0]       hold_code_reg, hold_code_next;
   logic             hold_en_reg, hold_en_next;
   logic [7:0]       y_reg, y_next;
   logic             y_valid_reg, y_valid_next;

   logic       accept;
   logic       load;
   logic       cnt_zero;
   logic [7:0] dec;

   // Buffered code decoded one bit per lane; a null pulse leaves every lane low.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_dec
         assign dec[gi] = hold_en_reg && (hold_code_reg == 3'(gi));
      end
   endgenerate

   assign cnt_zero = (cnt_reg == '0);
   assign accept   = in_valid && !hold_full_reg;
   // Accept needs an empty buffer and load a full one, so they never coincide.
   assign load     = hold_full_reg &&
                     ((state_reg == ST_IDLE) ||
                      (state_reg == ST_DRIVE && cnt_zero && GAP_LEN == 0) ||
                      (state_reg == ST_GAP && cnt_zero));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         hold_full_reg <= 1'b0;
         hold_code_reg <= 3'd0;
         hold_en_reg   <= 1'b0;
         y_reg         <= 8'h00;
         y_valid_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         hold_full_reg <= hold_full_next;
         hold_code_reg <= hold_code_next;
         hold_en_reg   <= hold_en_next;
         y_reg         <= y_next;
         y_valid_reg   <= y_valid_next;
      end
   end

   // Next-state and duration counter
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (load) begin
         state_next = ST_DRIVE;
         cnt_next   = PULSE_RELOAD;
      end else begin
         case (state_reg)
            ST_DRIVE: begin
               if (!cnt_zero) begin
                  cnt_next = cnt_reg - 1'b1;
               end else if (GAP_LEN > 0) begin
                  state_next = ST_GAP;
                  cnt_next   = GAP_RELOAD;
               end else begin
                  state_next = ST_IDLE;
                  cnt_next   = '0;
               end
            end
            ST_GAP: begin
               if (!cnt_zero) begin
                  cnt_next = cnt_reg - 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end
            default: begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // Holding buffer and registered strobe outputs
   always_comb begin
      hold_full_next = hold_full_reg;
      hold_code_next = hold_code_reg;
      hold_en_next   = hold_en_reg;
      y_next         = 8'h00;
      y_valid_next   = 1'b0;

      if (accept) begin
         hold_full_next = 1'b1;
         hold_code_next = in_code;
         hold_en_next   = in_en;
      end else if (load) begin
         hold_full_next = 1'b0;
      end

      if (load) begin
         y_next       = dec;
         y_valid_next = 1'b1;
      end else if (state_reg == ST_DRIVE && !cnt_zero) begin
         y_next       = y_reg;
         y_valid_next = y_valid_reg;
      end
   end

   assign in_ready = !hold_full_reg;
   assign y        = y_reg;
   assign y_valid  = y_valid_reg;
   assign y_last   = (state_reg == ST_DRIVE) && cnt_zero;
   assign busy     = (state_reg != ST_IDLE) || hold_full_reg;

endmodule

// File: tb/tb_decoder8_pulse.sv
// Directed bench for decoder8_pulse: one instance with a gap (4/1) and one
// gapless instance (2/0), checked against hand-computed strobe sequences.
module tb_decoder8_pulse;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       v0 = 1'b0, en0 = 1'b0, rdy0, yv0, yl0, busy0;
   logic [2:0] c0 = 3'd0;
   logic [7:0] y0;
   logic       v1 = 1'b0, en1 = 1'b0, rdy1, yv1, yl1, busy1;
   logic [2:0] c1 = 3'd0;
   logic [7:0] y1;

   decoder8_pulse #(.PULSE_LEN(4), .GAP_LEN(1), .CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_code(c0),
      .in_en(en0), .y(y0), .y_valid(yv0), .y_last(yl0), .busy(busy0));

   decoder8_pulse #(.PULSE_LEN(2), .GAP_LEN(0), .CNT_W(8)) u1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_code(c1),
      .in_en(en1), .y(y1), .y_valid(yv1), .y_last(yl1), .busy(busy1));

   int tests = 0;
   int fails = 0;

   logic [7:0] obs_q[$];
   int         len_q[$];
   logic [7:0] exp_q[$];
   logic       prev_valid = 1'b0;
   logic       prev_last  = 1'b0;
   int         run_len    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Advance one edge, then record pulse-window starts/lengths of u0.
   task automatic tick();
      @(posedge clk);
      #1;
      if (yv0) begin
         if (!prev_valid || prev_last) begin
            obs_q.push_back(y0);
            run_len = 0;
         end
         run_len++;
         if (yl0) len_q.push_back(run_len);
      end
      prev_valid = yv0;
      prev_last  = yl0;
   endtask

   task automatic clear_q();
      obs_q.delete();
      len_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int k;
      int cyc;
      int cnt;
      logic [7:0] oh;

      // Reset state
      repeat (2) tick();
      check("rst_y", 32'(y0), 32'h00);
      check("rst_yv", 32'(yv0), 32'h0);
      check("rst_last", 32'(yl0), 32'h0);
      check("rst_ready", 32'(rdy0), 32'h1);
      check("rst_busy", 32'(busy0), 32'h0);
      rst = 1'b0;
      tick();

      // Single transfer code 5
      v0 = 1'b1; c0 = 3'd5; en0 = 1'b1;
      tick();
      v0 = 1'b0;
      check("t1_ready_after_acc", 32'(rdy0), 32'h0);
      check("t1_busy_after_acc", 32'(busy0), 32'h1);
      check("t1_y_before_load", 32'(y0), 32'h00);
      tick();
      check("t1_y_load", 32'(y0), 32'h20);
      check("t1_yv_load", 32'(yv0), 32'h1);
      check("t1_ready_load", 32'(rdy0), 32'h1);
      check("t1_last_c1", 32'(yl0), 32'h0);
      tick();
      tick();
      check("t1_y_c3", 32'(y0), 32'h20);
      check("t1_last_c3", 32'(yl0), 32'h0);
      tick();
      check("t1_y_c4", 32'(y0), 32'h20);
      check("t1_last_c4", 32'(yl0), 32'h1);
      tick();
      check("t1_y_gap", 32'(y0), 32'h00);
      check("t1_yv_gap", 32'(yv0), 32'h0);
      check("t1_busy_gap", 32'(busy0), 32'h1);
      tick();
      check("t1_busy_idle", 32'(busy0), 32'h0);
      tick();

      // Sweep codes 0..7 with the source always valid
      clear_q();
      k = 0;
      cyc = 0;
      v0 = 1'b1; en0 = 1'b1; c0 = 3'd0;
      while (obs_q.size() < 8 && cyc < 120) begin
         if (v0 && rdy0) k++;
         if (y0 !== 8'h00 && yv0 !== 1'b1) check("sweep_y_outside_window", 32'(y0), 32'h00);
         tick();
         cyc++;
         if (k >= 8) v0 = 1'b0;
         else c0 = 3'(k);
      end
      v0 = 1'b0;
      repeat (8) tick();
      check("sweep_pulse_count", 32'(obs_q.size()), 32'd8);
      check("sweep_len_count", 32'(len_q.size()), 32'd8);
      for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
         oh = 8'h01 << i;
         check($sformatf("sweep_y%0d", i), 32'(obs_q[i]), 32'(oh));
      end
      for (int i = 0; i < len_q.size(); i++)
         check($sformatf("sweep_len%0d", i), 32'(len_q[i]), 32'd4);

      // Gapless instance: codes 3 then 6
      v1 = 1'b1; c1 = 3'd3; en1 = 1'b1;
      tick();
      c1 = 3'd6;
      tick();
      check("g0_y_a1", 32'(y1), 32'h08);
      check("g0_ready_a1", 32'(rdy1), 32'h1);
      tick();
      v1 = 1'b0;
      check("g0_y_a2", 32'(y1), 32'h08);
      check("g0_last_a2", 32'(yl1), 32'h1);
      tick();
      check("g0_y_a3", 32'(y1), 32'h40);
      check("g0_yv_a3", 32'(yv1), 32'h1);
      tick();
      check("g0_y_a4", 32'(y1), 32'h40);
      check("g0_last_a4", 32'(yl1), 32'h1);
      tick();
      check("g0_y_a5", 32'(y1), 32'h00);
      check("g0_yv_a5", 32'(yv1), 32'h0);

      // Null pulse: en=0, code 7
      repeat (2) tick();
      v0 = 1'b1; c0 = 3'd7; en0 = 1'b0;
      tick();
      v0 = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("null_y%0d", i), 32'(y0), 32'h00);
         check($sformatf("null_yv%0d", i), 32'(yv0), 32'h1);
         if (yl0) cnt++;
      end
      check("null_last_once", 32'(cnt), 32'd1);
      tick();
      check("null_yv_end", 32'(yv0), 32'h0);
      repeat (2) tick();

      // Backpressure: a new code every cycle, only ready cycles accept
      clear_q();
      en0 = 1'b1;
      v0 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         c0 = 3'((i * 3 + 1) % 8);
         if (rdy0) exp_q.push_back(8'h01 << c0);
         tick();
      end
      v0 = 1'b0;
      cyc = 0;
      while ((busy0 || obs_q.size() < exp_q.size()) && cyc < 100) begin
         tick();
         cyc++;
      end
      check("bp_drain_timeout", 32'(cyc < 100), 32'h1);
      check("bp_count", 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check($sformatf("bp_y%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));

      // Asynchronous reset mid-DRIVE with a pending code
      v0 = 1'b1; c0 = 3'd2;
      tick();
      c0 = 3'd4;
      tick();
      tick();
      v0 = 1'b0;
      check("ar_pre_y", 32'(y0), 32'h04);
      check("ar_pre_ready", 32'(rdy0), 32'h0);
      #2;
      rst = 1'b1;
      #1;
      check("ar_y", 32'(y0), 32'h00);
      check("ar_yv", 32'(yv0), 32'h0);
      check("ar_ready", 32'(rdy0), 32'h1);
      check("ar_busy", 32'(busy0), 32'h0);
      #1;
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (yv0 || y0 != 8'h00) cnt++;
      end
      check("ar_no_pulse_after", 32'(cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
